// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: run controller for RISCVSoC test runs.
// On a valid start it latches the selected test's cycle budget, holds the SoC
// in reset, lets it run until the CPU raises halt_req or the budget expires,
// pulses debug to trigger the register/memory dump, then parks the SoC and
// reports status.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle run request, honoured in IDLE or DONE
//   test_sel   test index sampled with start
//   halt_req   CPU end-of-test indication, sampled only in RUN
//   abort      return to IDLE from any state
//   soc_rst    active-high reset to the SoC
//   debug      dump pulse to the SoC
//   busy       run in progress (RESET, RUN, DEBUG)
//   done       run finished
//   timed_out  in DONE: 1 = budget expired, 0 = halted by the CPU
//   bad_sel    sticky: last start had an out-of-range test_sel
//   cycles     RUN cycles consumed, frozen outside RUN
module soc_run_ctrl #(
  parameter int unsigned               NUM_TESTS  = 5,
  parameter int unsigned               SEL_W      = 3,
  parameter int unsigned               CNT_W      = 20,
  parameter logic [NUM_TESTS*CNT_W-1:0] BUDGETS   =
    {20'd250000, 20'd250000, 20'd15000, 20'd15000, 20'd10000},
  parameter int unsigned               RST_CYCLES = 1,
  parameter int unsigned               DBG_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] test_sel,
  input  logic             halt_req,
  input  logic             abort,
  output logic             soc_rst,
  output logic             debug,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             bad_sel,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned RST_N  = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
  localparam int unsigned DBG_N  = (DBG_CYCLES == 0) ? 1 : DBG_CYCLES;
  localparam int unsigned PH_MAX = (RST_N > DBG_N) ? RST_N : DBG_N;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DEBUG,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q, timed_out_d;
  logic             bad_sel_q, bad_sel_d;
  logic             soc_rst_q, soc_rst_d;
  logic             debug_q, debug_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sel_valid;
  logic [CNT_W-1:0] budget_sel;
  logic [CNT_W-1:0] last_cnt;

  assign sel_valid = (32'(test_sel) < NUM_TESTS);

  // Budget lookup only ever indexes in-range entries.
  always_comb begin
    budget_sel = '0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      if (32'(test_sel) == i) begin
        budget_sel = BUDGETS[i*CNT_W +: CNT_W];
      end
    end
  end

  // A zero budget behaves like a budget of one cycle.
  assign last_cnt = (budget_q == '0) ? '0 : budget_q - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    budget_d    = budget_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    bad_sel_d   = bad_sel_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (sel_valid) begin
            state_d     = S_RESET;
            phase_d     = PH_W'(RST_N - 1);
            budget_d    = budget_sel;
            cnt_d       = '0;
            timed_out_d = 1'b0;
            bad_sel_d   = 1'b0;
          end else begin
            bad_sel_d = 1'b1;
          end
        end
      end
      S_RESET: begin
        if (phase_q == '0) begin
          state_d = S_RUN;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // halt_req has priority over budget expiry in the same cycle
        if (halt_req) begin
          state_d     = S_DEBUG;
          phase_d     = PH_W'(DBG_N - 1);
          timed_out_d = 1'b0;
        end else if (cnt_q >= last_cnt) begin
          state_d     = S_DEBUG;
          phase_d     = PH_W'(DBG_N - 1);
          timed_out_d = 1'b1;
        end
      end
      S_DEBUG: begin
        if (phase_q == '0) begin
          state_d = S_DONE;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards everything above: the abort edge itself is not counted
    // as a RUN cycle and all status stays as it was.
    if (abort) begin
      state_d     = S_IDLE;
      phase_d     = phase_q;
      budget_d    = budget_q;
      cnt_d       = cnt_q;
      timed_out_d = timed_out_q;
      bad_sel_d   = bad_sel_q;
    end
  end

  // Status outputs follow the state one cycle later; abort parks them at
  // once so debug never outlives the abort edge.
  always_comb begin
    soc_rst_d = (state_q == S_IDLE) || (state_q == S_RESET) || (state_q == S_DONE);
    debug_d   = (state_q == S_DEBUG);
    busy_d    = (state_q == S_RESET) || (state_q == S_RUN) || (state_q == S_DEBUG);
    done_d    = (state_q == S_DONE);
    if (abort) begin
      soc_rst_d = 1'b1;
      debug_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      budget_q    <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      bad_sel_q   <= 1'b0;
      soc_rst_q   <= 1'b1;
      debug_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      budget_q    <= budget_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      bad_sel_q   <= bad_sel_d;
      soc_rst_q   <= soc_rst_d;
      debug_q     <= debug_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign soc_rst   = soc_rst_q;
  assign debug     = debug_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign bad_sel   = bad_sel_q;
  assign cycles    = cnt_q;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Testbench for soc_run_ctrl with shortened budgets and stretched reset/debug
// phases. Expected waveforms are derived from run timeline arithmetic.
module tb_soc_run_ctrl;
  localparam int R = 2;  // reset phase cycles
  localparam int D = 3;  // debug pulse cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  test_sel;
  logic        halt_req;
  logic        abort;
  logic        soc_rst;
  logic        debug;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic        bad_sel;
  logic [19:0] cycles;

  int checks   = 0;
  int failures = 0;
  int budget_tab [5] = '{10000, 0, 1500, 1, 2000};

  soc_run_ctrl #(
    .NUM_TESTS (5),
    .SEL_W     (3),
    .CNT_W     (20),
    .BUDGETS   ({20'd2000, 20'd1, 20'd1500, 20'd0, 20'd10000}),
    .RST_CYCLES(2),
    .DBG_CYCLES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .test_sel (test_sel),
    .halt_req (halt_req),
    .abort    (abort),
    .soc_rst  (soc_rst),
    .debug    (debug),
    .busy     (busy),
    .done     (done),
    .timed_out(timed_out),
    .bad_sel  (bad_sel),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Full run from IDLE/DONE. halt_at: RUN cycle (1-based) with halt_req high,
  // 0 = none. noise: extra start during RUN, which must be ignored.
  task automatic run_check(input int sel, input int halt_at, input bit noise);
    int e, l, tot, exp_cyc;
    bit exp_to;
    logic [3:0] exp_vec, obs_vec;
    e = (budget_tab[sel] == 0) ? 1 : budget_tab[sel];
    if (halt_at >= 1 && halt_at <= e) begin
      l = halt_at; exp_to = 1'b0;
    end else begin
      l = e; exp_to = 1'b1;
    end
    tot = R + l + D;
    start = 1'b1; test_sel = 3'(sel);
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= tot + 2; t++) begin
      @(negedge clk);
      exp_vec = {((t <= R) || (t > tot)), ((t > R + l) && (t <= tot)),
                 (t <= tot), (t > tot)};
      obs_vec = {soc_rst, debug, busy, done};
      exp_cyc = (t <= R) ? 0 : ((t - R > l) ? l : t - R);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL run_outputs sel=%0d t=%0d {rst,dbg,busy,done} got=%b want=%b",
                 sel, t, obs_vec, exp_vec);
      end
      checks++;
      if (cycles !== 20'(exp_cyc)) begin
        failures++;
        $display("FAIL run_cycles sel=%0d t=%0d got=%0d want=%0d", sel, t, cycles, exp_cyc);
      end
      checks++;
      if (bad_sel !== 1'b0) begin
        failures++;
        $display("FAIL run_bad_sel sel=%0d t=%0d got=%b want=0", sel, t, bad_sel);
      end
      if (t > tot) begin
        checks++;
        if (timed_out !== exp_to) begin
          failures++;
          $display("FAIL run_timed_out sel=%0d halt=%0d got=%b want=%b",
                   sel, halt_at, timed_out, exp_to);
        end
      end
      halt_req = (halt_at >= 1) && (t == R + halt_at - 1);
      start    = noise && (l >= 3) && (t == R + 1);
      test_sel = start ? 3'($urandom_range(0, 7)) : 3'(sel);
    end
    halt_req = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] obs;
    rst = 1'b1; start = 1'b0; test_sel = '0; halt_req = 1'b0; abort = 1'b0;
    #1 rst = 1'b0;
    #1;
    obs = {soc_rst, debug, busy, done, timed_out, bad_sel};
    checks++;
    if (obs !== 6'b100000 || cycles !== 20'd0) begin
      failures++;
      $display("FAIL reset_async got=%b/%0d want=100000/0", obs, cycles);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {soc_rst, debug, busy, done, timed_out, bad_sel};
    checks++;
    if (obs !== 6'b100000 || cycles !== 20'd0) begin
      failures++;
      $display("FAIL reset_release got=%b/%0d want=100000/0", obs, cycles);
    end
  endtask

  task automatic test_bad_sel;
    logic [3:0] obs;
    // out-of-range selections in IDLE
    for (int s = 5; s <= 7; s += 1) begin
      start = 1'b1; test_sel = 3'(s);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      obs = {soc_rst, busy, done, bad_sel};
      checks++;
      if (obs !== 4'b1001) begin
        failures++;
        $display("FAIL bad_sel_idle sel=%0d {rst,busy,done,bad} got=%b want=1001", s, obs);
      end
    end
    run_check(1, 0, 1'b0);
    // invalid start in DONE: flag set, status frozen
    start = 1'b1; test_sel = 3'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    obs = {soc_rst, busy, done, bad_sel};
    checks++;
    if (obs !== 4'b1011 || cycles !== 20'd1 || timed_out !== 1'b1) begin
      failures++;
      $display("FAIL bad_sel_done got=%b cyc=%0d to=%b want=1011 cyc=1 to=1",
               obs, cycles, timed_out);
    end
  endtask

  task automatic test_timeout;
    run_check(4, 0, 1'b1);
    run_check(3, 0, 1'b0);
    run_check(1, 0, 1'b1);
  endtask

  task automatic test_halt;
    run_check(2, 1200, 1'b1);
    run_check(4, int'($urandom_range(2, 1999)), 1'b1);
    run_check(2, 1501, 1'b0);
  endtask

  task automatic test_halt_last;
    run_check(0, 10000, 1'b0);
    run_check(3, 1, 1'b0);
    run_check(1, 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int sel, e, h, mode;
    for (int i = 0; i < 8; i++) begin
      sel  = int'($urandom_range(1, 4));
      e    = (budget_tab[sel] == 0) ? 1 : budget_tab[sel];
      mode = int'($urandom_range(0, 2));
      case (mode)
        0:       h = 0;
        1:       h = int'($urandom_range(1, e));
        default: h = e + int'($urandom_range(1, 3));
      endcase
      run_check(sel, h, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_abort;
    logic [3:0] obs;
    // abort (with a coincident halt) in RUN cycle 500
    start = 1'b1; test_sel = 3'd4;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= R + 499; t++) @(negedge clk);
    abort = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    abort = 1'b0; halt_req = 1'b0;
    obs = {soc_rst, debug, busy, done};
    checks++;
    if (obs !== 4'b1000 || cycles !== 20'd499 || timed_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_run got=%b cyc=%0d to=%b want=1000 cyc=499 to=0",
               obs, cycles, timed_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({soc_rst, busy, cycles} !== {1'b1, 1'b0, 20'd499}) begin
      failures++;
      $display("FAIL abort_frozen rst=%b busy=%b cyc=%0d want rst=1 busy=0 cyc=499",
               soc_rst, busy, cycles);
    end
    // abort outranks a simultaneous start
    start = 1'b1; abort = 1'b1; test_sel = 3'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({soc_rst, busy, cycles} !== {1'b1, 1'b0, 20'd499}) begin
      failures++;
      $display("FAIL abort_vs_start rst=%b busy=%b cyc=%0d want rst=1 busy=0 cyc=499",
               soc_rst, busy, cycles);
    end
    // abort while debug is high
    start = 1'b1; test_sel = 3'd3;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= R + 2; t++) @(negedge clk);
    checks++;
    if (debug !== 1'b1) begin
      failures++;
      $display("FAIL abort_dbg_pre debug got=%b want=1", debug);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    obs = {soc_rst, debug, busy, done};
    checks++;
    if (obs !== 4'b1000 || cycles !== 20'd1 || timed_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_debug got=%b cyc=%0d to=%b want=1000 cyc=1 to=1",
               obs, cycles, timed_out);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [5:0] obs;
    start = 1'b1; test_sel = 3'd4;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= R + 100; t++) @(negedge clk);
    checks++;
    if (soc_rst !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_pre rst=%b busy=%b want rst=0 busy=1", soc_rst, busy);
    end
    #2 rst = 1'b0;
    #1;
    obs = {soc_rst, debug, busy, done, timed_out, bad_sel};
    checks++;
    if (obs !== 6'b100000 || cycles !== 20'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%b/%0d want=100000/0", obs, cycles);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {soc_rst, debug, busy, done, timed_out, bad_sel};
    checks++;
    if (obs !== 6'b100000 || cycles !== 20'd0) begin
      failures++;
      $display("FAIL midrun_release got=%b/%0d want=100000/0", obs, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_bad_sel();
    test_timeout();
    test_halt();
    test_halt_last();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
